adc_scan_sequencer: RTL and testbench
=====================================

Name: adc_scan_sequencer

Overview:
- Parametrised successor to the single-channel ADC front end; sits between the SPI ADC pins and the sample/UART packetiser.
- Scans a masked set of up to NUM_CH channels of an MCP3208-class SPI ADC on a programmable periodic tick.
- Emits channel-tagged samples on a valid/ready stream with a 1-deep output register.
- Flags output overruns and late scan ticks.

Parameters:
- NUM_CH, 4, number of scannable channels (1..2**ADDR_W)
- ADDR_W, 3, channel address bits sent in the SPI command
- SAMPLE_W, 12, ADC result width
- CLK_DIV, 25, clk cycles per SCLK half-period (>=1)
- SAMPLE_PERIOD, 50000, clk cycles between scan ticks (>= one full scan)
- CH_W, $clog2(NUM_CH) (min 1), derived tag width, localparam

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- en_i  in  1  scan enable
- ch_mask_i  in  NUM_CH  per-channel enable; sampled at each tick
- adc_sclk_o  out  1  SPI clock, mode 0, idle low
- adc_cs_n_o  out  1  SPI chip select, active low
- adc_mosi_o  out  1  SPI command data
- adc_miso_i  in  1  SPI result data
- sample_o  out  SAMPLE_W  converted sample
- sample_ch_o  out  CH_W  channel of sample_o
- sample_valid_o  out  1  stream valid
- sample_ready_i  in  1  stream ready
- busy_o  out  1  scan in progress
- overrun_o  out  1  1-cycle pulse: sample dropped
- scan_late_o  out  1  1-cycle pulse: tick arrived during active scan

Behaviour:
- Reset: sclk=0, cs_n=1, mosi=0, sample_o=0, sample_ch_o=0, sample_valid_o=0, busy_o=0, overrun_o=0, scan_late_o=0; tick counter=0; FSM=IDLE. Reset mid-frame drops CS on the next edge; no partial sample is emitted.
- Tick counter: runs only while en_i=1; cleared while en_i=0. It wraps at SAMPLE_PERIOD-1 and the tick pulses on the wrap. The first tick occurs SAMPLE_PERIOD cycles after en_i rises.
- Scan: on a tick with ch_mask_i!=0, latch the mask. Convert set channels in ascending index order, one frame each. Tick with mask=0: no scan, no pulse.
- Frame: FRAME_BITS = 3+ADDR_W+SAMPLE_W (18 at defaults).
  - MOSI sends, MSB first: start=1, sgl=1, channel address (ADDR_W bits), then 0 for the remaining bits.
  - SCLK low CLK_DIV cycles, then high CLK_DIV cycles, per bit.
  - MOSI updates at the start of each low phase.
  - adc_miso_i is registered on the clk where SCLK rises.
  - The last SAMPLE_W rising-edge samples form the result, MSB first. The null bit is ignored.
- FSM states:
  - IDLE
  - CS_SETUP: cs_n=0 for CLK_DIV cycles
  - SHIFT: FRAME_BITS SCLK periods
  - CS_HOLD: sclk low, CLK_DIV cycles, then cs_n=1
  - GAP: cs_n=1 for CLK_DIV cycles
  - Transitions: next channel → CS_SETUP; none → IDLE. busy_o=1 in all states except IDLE.
- Output:
  - At CS_HOLD exit, if sample_valid_o=0 or sample_ready_i=1 that cycle, load sample/ch and set valid.
  - Otherwise discard the new sample and pulse overrun_o; the held sample is unchanged.
  - Valid drops on the handshake unless reloaded the same cycle.
  - sample_o/ch are stable while valid=1 and ready=0.
- Late tick: a tick while busy_o=1 is discarded and scan_late_o pulses; the current scan continues.
- en_i falling mid-scan: the current frame completes and its sample is delivered normally. No further channels are converted; then IDLE.
- Latency: first cs_n fall 1 cycle after tick. Valid rises 1 cycle after CS_HOLD ends.

Optional Feature:
- Macro ADC_TEST_PATTERN_EN.
- Defined: adds port test_mode_i (in, 1). When 1, the SPI frame still runs but the loaded result is a per-channel SAMPLE_W ramp counter. The counter starts at 0 after reset and increments (wrapping) after each load for that channel.
- Undefined: no port, no counters; result always comes from MISO.

Decomposition:
- Package adc_seq_pkg holds:
  - the FSM state enum
  - the FRAME_BITS function of (ADDR_W, SAMPLE_W)
  - command-bit constants START_BIT=1, SGL_BIT=1
- Sub-module adc_spi_frame performs one frame (start/addr in, done pulse + result out).
- The sequencer owns the tick, mask scan, and output register.

Test Plan (CLK_DIV=2, SAMPLE_PERIOD=400, NUM_CH=4):
- Reset sequence → all outputs at reset values. en_i=1 → first cs_n fall at cycle 401 after en_i rises.
- mask=4'b1010, ready=1, ADC model returns 12'hA5C on ch1 and 12'h3F0 on ch3 →
  - two frames, MOSI commands 11001 and 11011
  - outputs (1,A5C) then (3,3F0), no overrun
- ready=0 throughout a mask=4'b0111 scan → ch0 sample held; overrun_o pulses twice (ch1, ch2); sample_o stays ch0.
- SAMPLE_PERIOD=60 with mask=4'hF (scan > period) → scan_late_o pulses; scan order stays 0,1,2,3.
- en_i dropped during ch1 frame of a mask=4'hF scan → ch1 delivered; no ch2 frame; busy_o falls.
- rst_n low mid-SHIFT → next cycle cs_n=1, sclk=0, valid=0. With ADC_TEST_PATTERN_EN and test_mode_i=1: ch0 yields 0,1,2 on successive scans.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared state encoding and frame constants
// for the multi-channel ADC scan sequencer.
package adc_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT,
    S_CS_HOLD,
    S_GAP
  } state_e;

  localparam logic START_BIT = 1'b1;
  localparam logic SGL_BIT   = 1'b1;

  function automatic int frame_bits(input int addr_w, input int sample_w);
    return 3 + addr_w + sample_w;
  endfunction

endpackage

// File: rtl/adc_spi_frame.sv
// adc_spi_frame: one SPI mode-0 conversion frame with CS setup/hold
// and inter-frame gap; back-to-back frames chain from GAP.
module adc_spi_frame
  import adc_seq_pkg::*;
#(
  parameter int ADDR_W   = 3,
  parameter int SAMPLE_W = 12,
  parameter int CLK_DIV  = 25
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_i,
  input  logic [ADDR_W-1:0]   addr_i,
  output logic                take_o,
  output logic                done_o,
  output logic [SAMPLE_W-1:0] result_o,
  output logic                busy_o,
  output logic                sclk_o,
  output logic                cs_n_o,
  output logic                mosi_o,
  input  logic                miso_i
);

  localparam int FB    = frame_bits(ADDR_W, SAMPLE_W);
  localparam int BIT_W = $clog2(FB);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [FB-1:0]       cmd_q, cmd_d;
  logic [SAMPLE_W-1:0] res_q, res_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                div_end;
  logic [FB-1:0]       cmd_new;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    cmd_d   = cmd_q;
    res_d   = res_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    take_o  = 1'b0;
    done_o  = 1'b0;
    div_end = div_q == DIV_W'(CLK_DIV - 1);
    div_d   = div_end ? '0 : div_q + 1'b1;
    cmd_new = {START_BIT, SGL_BIT, addr_i, {(SAMPLE_W + 1){1'b0}}};
    unique case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (req_i) begin
          take_o  = 1'b1;
          cmd_d   = cmd_new;
          state_d = S_CS_SETUP;
        end
      end
      S_CS_SETUP: begin
        if (div_end) begin
          state_d = S_SHIFT;
          bit_d   = '0;
          mosi_d  = cmd_q[FB-1];
          cmd_d   = cmd_q << 1;
        end
      end
      S_SHIFT: begin
        if (div_end && !sclk_q) begin
          sclk_d = 1'b1;
          res_d  = {res_q[SAMPLE_W-2:0], miso_i};
        end else if (div_end) begin
          sclk_d = 1'b0;
          if (bit_q == BIT_W'(FB - 1)) begin
            state_d = S_CS_HOLD;
            mosi_d  = 1'b0;
          end else begin
            bit_d  = bit_q + 1'b1;
            mosi_d = cmd_q[FB-1];
            cmd_d  = cmd_q << 1;
          end
        end
      end
      S_CS_HOLD: begin
        if (div_end) begin
          done_o  = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (div_end && req_i) begin
          take_o  = 1'b1;
          cmd_d   = cmd_new;
          state_d = S_CS_SETUP;
        end else if (div_end) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      cmd_q   <= '0;
      res_q   <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      cmd_q   <= cmd_d;
      res_q   <= res_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  assign result_o = res_q;
  assign busy_o   = state_q != S_IDLE;
  assign sclk_o   = sclk_q;
  assign mosi_o   = mosi_q;
  assign cs_n_o   = !(state_q inside {S_CS_SETUP, S_SHIFT, S_CS_HOLD});

endmodule

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: periodic masked scan of an MCP3208-class SPI ADC.
// ADC_TEST_PATTERN_EN adds test_mode_i, replacing results with per-channel ramps.
module adc_scan_sequencer
  import adc_seq_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int ADDR_W        = 3,
  parameter int SAMPLE_W      = 12,
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_PERIOD = 50000,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic [NUM_CH-1:0]   ch_mask_i,
`ifdef ADC_TEST_PATTERN_EN
  input  logic                test_mode_i,
`endif
  output logic                adc_sclk_o,
  output logic                adc_cs_n_o,
  output logic                adc_mosi_o,
  input  logic                adc_miso_i,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic [CH_W-1:0]     sample_ch_o,
  output logic                sample_valid_o,
  input  logic                sample_ready_i,
  output logic                busy_o,
  output logic                overrun_o,
  output logic                scan_late_o
);

  localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tick_q, tick_d;
  logic [NUM_CH-1:0]   pend_q, pend_d, pend_cur;
  logic [CH_W-1:0]     cur_ch_q, cur_ch_d, nxt_ch;
  logic [SAMPLE_W-1:0] sample_q, sample_d, frame_res, res_sel;
  logic [CH_W-1:0]     sch_q, sch_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;
  logic                late_q, late_d;
  logic                busy, req, take, done, scan_go, load;
  logic [ADDR_W-1:0]   addr;

  function automatic logic [CH_W-1:0] low_idx(input logic [NUM_CH-1:0] m);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (en_i) begin
      tick_d = cnt_q == CNT_W'(SAMPLE_PERIOD - 1);
      cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
    end
    // A fresh tick feeds the frame engine the same cycle it is seen.
    scan_go  = tick_q && en_i && !busy && (|ch_mask_i);
    pend_cur = scan_go ? ch_mask_i : pend_q;
    nxt_ch   = low_idx(pend_cur);
    addr     = ADDR_W'(nxt_ch);
    req      = en_i && (|pend_cur);
    pend_d   = en_i ? pend_cur : '0;
    cur_ch_d = cur_ch_q;
    if (take) begin
      pend_d[nxt_ch] = 1'b0;
      cur_ch_d       = nxt_ch;
    end
    late_d   = tick_q && busy;
    load     = done && (!valid_q || sample_ready_i);
    sample_d = sample_q;
    sch_d    = sch_q;
    valid_d  = valid_q;
    ovr_d    = 1'b0;
    if (load) begin
      sample_d = res_sel;
      sch_d    = cur_ch_q;
      valid_d  = 1'b1;
    end else if (done) begin
      ovr_d = 1'b1;
    end else if (valid_q && sample_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      pend_q   <= '0;
      cur_ch_q <= '0;
      sample_q <= '0;
      sch_q    <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
      late_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      pend_q   <= pend_d;
      cur_ch_q <= cur_ch_d;
      sample_q <= sample_d;
      sch_q    <= sch_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
      late_q   <= late_d;
    end
  end

`ifdef ADC_TEST_PATTERN_EN
  logic [SAMPLE_W-1:0] ramp_q [NUM_CH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) ramp_q[i] <= '0;
    end else if (load && test_mode_i) begin
      ramp_q[cur_ch_q] <= ramp_q[cur_ch_q] + 1'b1;
    end
  end

  assign res_sel = test_mode_i ? ramp_q[cur_ch_q] : frame_res;
`else
  assign res_sel = frame_res;
`endif

  adc_spi_frame #(
    .ADDR_W  (ADDR_W),
    .SAMPLE_W(SAMPLE_W),
    .CLK_DIV (CLK_DIV)
  ) u_frame (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req),
    .addr_i  (addr),
    .take_o  (take),
    .done_o  (done),
    .result_o(frame_res),
    .busy_o  (busy),
    .sclk_o  (adc_sclk_o),
    .cs_n_o  (adc_cs_n_o),
    .mosi_o  (adc_mosi_o),
    .miso_i  (adc_miso_i)
  );

  assign sample_o       = sample_q;
  assign sample_ch_o    = sch_q;
  assign sample_valid_o = valid_q;
  assign busy_o         = busy;
  assign overrun_o      = ovr_q;
  assign scan_late_o    = late_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: scoreboard bench with an MCP3208-style ADC model;
// a second instance with a short period exercises late ticks.
module tb_adc_scan_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic ready = 1'b0;
  logic miso = 1'b0;
  logic tmode = 1'b0;
  logic [3:0] mask = '0;
  logic sclk, cs_n, mosi, valid, busy, ovr, late;
  logic [11:0] sample;
  logic [1:0] sch;

  logic l_en = 1'b0;
  logic [3:0] l_mask = 4'hF;
  logic l_sclk, l_cs_n, l_mosi, l_valid, l_busy, l_ovr, l_late;
  logic [11:0] l_sample;
  logic [1:0] l_ch;

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  int late_cnt = 0;
  int frames = 0;
  int l_nout = 0;
  int n;
  logic [1:0] l_exp = '0;

  logic [13:0] exp_q[$];
  logic [17:0] cmd_q[$];
  logic [13:0] e;
  logic [11:0] adc_val[4] = '{12'h123, 12'hA5C, 12'h8E7, 12'h3F0};

  always #5 clk = ~clk;

  adc_scan_sequencer #(
    .NUM_CH(4), .ADDR_W(3), .SAMPLE_W(12),
    .CLK_DIV(2), .SAMPLE_PERIOD(400)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .ch_mask_i(mask),
`ifdef ADC_TEST_PATTERN_EN
    .test_mode_i(tmode),
`endif
    .adc_sclk_o(sclk), .adc_cs_n_o(cs_n), .adc_mosi_o(mosi),
    .adc_miso_i(miso), .sample_o(sample), .sample_ch_o(sch),
    .sample_valid_o(valid), .sample_ready_i(ready), .busy_o(busy),
    .overrun_o(ovr), .scan_late_o(late)
  );

  adc_scan_sequencer #(
    .NUM_CH(4), .ADDR_W(3), .SAMPLE_W(12),
    .CLK_DIV(2), .SAMPLE_PERIOD(60)
  ) u_late (
    .clk(clk), .rst_n(rst_n), .en_i(l_en), .ch_mask_i(l_mask),
`ifdef ADC_TEST_PATTERN_EN
    .test_mode_i(1'b0),
`endif
    .adc_sclk_o(l_sclk), .adc_cs_n_o(l_cs_n), .adc_mosi_o(l_mosi),
    .adc_miso_i(1'b0), .sample_o(l_sample), .sample_ch_o(l_ch),
    .sample_valid_o(l_valid), .sample_ready_i(1'b1), .busy_o(l_busy),
    .overrun_o(l_ovr), .scan_late_o(l_late)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] exp_cmd(input int ch);
    logic [2:0] a;
    a = 3'(ch);
    return {1'b1, 1'b1, a, 13'b0};
  endfunction

  task automatic wait_for(input int sel, input int maxc,
                          input string tag, output int cnt);
    logic hit;
    hit = 1'b0;
    cnt = 0;
    while (!hit && cnt < maxc) begin
      @(posedge clk);
      #1;
      cnt++;
      case (sel)
        0: hit = !cs_n;
        1: hit = cs_n;
        2: hit = !busy;
        3: hit = l_nout >= 8;
        default: hit = exp_q.size() == 0;
      endcase
    end
    chk(tag, {31'b0, hit}, 1);
  endtask

  // ADC model: records MOSI on SCLK rise, drives MISO for the next rise.
  int nrise = 0;
  logic [17:0] rec = '0;
  logic [1:0] a_ch = '0;
  logic [11:0] dv;
  logic sclk_p = 1'b0;
  logic cs_p = 1'b1;

  always @(negedge clk) begin
    if (!cs_n && cs_p) begin
      nrise = 0;
      rec = '0;
      frames++;
    end
    if (cs_n && !cs_p && nrise == 18) begin
      if (cmd_q.size() == 0) chk("cmd_q", cmd_q.size(), 1);
      else chk("mosi_cmd", {14'b0, rec}, {14'b0, cmd_q.pop_front()});
    end
    if (!cs_n && sclk && !sclk_p) begin
      rec = {rec[16:0], mosi};
      nrise++;
      if (nrise == 5) a_ch = rec[1:0];
    end
    dv = adc_val[a_ch];
    miso = (!cs_n && nrise >= 6 && nrise < 18) ? dv[17-nrise] : 1'b0;
    sclk_p = sclk;
    cs_p = cs_n;
  end

  always @(negedge clk) begin
    if (valid && ready) begin
      if (exp_q.size() == 0) chk("out_q", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        chk("out_ch", {30'b0, sch}, {30'b0, e[13:12]});
        chk("out_data", {20'b0, sample}, {20'b0, e[11:0]});
      end
    end
    if (ovr) ovr_cnt++;
    if (l_valid) begin
      chk("late_order", {30'b0, l_ch}, {30'b0, l_exp});
      l_exp = l_exp + 2'd1;
      l_nout++;
    end
    if (l_late) late_cnt++;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sclk", {31'b0, sclk}, 0);
    chk("rst_cs_n", {31'b0, cs_n}, 1);
    chk("rst_mosi", {31'b0, mosi}, 0);
    chk("rst_sample", {20'b0, sample}, 0);
    chk("rst_ch", {30'b0, sch}, 0);
    chk("rst_valid", {31'b0, valid}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_ovr_late", {30'b0, ovr, late}, 0);

    // Two-channel scan, first-frame latency
    rst_n = 1'b1;
    mask = 4'b1010;
    ready = 1'b1;
    exp_q.push_back({2'd1, 12'hA5C});
    exp_q.push_back({2'd3, 12'h3F0});
    cmd_q.push_back(exp_cmd(1));
    cmd_q.push_back(exp_cmd(3));
    @(posedge clk);
    #1;
    en = 1'b1;
    wait_for(0, 1000, "cs_fall1", n);
    chk("first_cs_lat", n, 401);
    chk("busy_hi", {31'b0, busy}, 1);
    wait_for(2, 1000, "scan1_done", n);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sb1_left", exp_q.size(), 0);
    chk("cmd1_left", cmd_q.size(), 0);
    chk("ovr1", ovr_cnt, 0);

    // Output stalled: ch0 held, ch1/ch2 dropped
    ready = 1'b0;
    mask = 4'b0111;
    ovr_cnt = 0;
    for (int i = 0; i < 3; i++) cmd_q.push_back(exp_cmd(i));
    en = 1'b1;
    wait_for(0, 1000, "cs_fall3", n);
    wait_for(2, 1000, "scan3_done", n);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("ovr_pulses", ovr_cnt, 2);
    chk("held_valid", {31'b0, valid}, 1);
    chk("held_ch", {30'b0, sch}, 0);
    chk("held_data", {20'b0, sample}, 32'h123);
    exp_q.push_back({2'd0, 12'h123});
    ready = 1'b1;
    wait_for(4, 20, "drain3", n);
    chk("cmd3_left", cmd_q.size(), 0);

    // en_i dropped during the ch1 frame
    mask = 4'hF;
    frames = 0;
    exp_q.push_back({2'd0, 12'h123});
    exp_q.push_back({2'd1, 12'hA5C});
    cmd_q.push_back(exp_cmd(0));
    cmd_q.push_back(exp_cmd(1));
    en = 1'b1;
    wait_for(0, 1000, "cs_fall4a", n);
    wait_for(1, 200, "cs_rise4", n);
    wait_for(0, 200, "cs_fall4b", n);
    repeat (10) @(posedge clk);
    #1;
    en = 1'b0;
    wait_for(2, 500, "scan4_done", n);
    repeat (5) @(posedge clk);
    #1;
    chk("frames_en_drop", frames, 2);
    chk("sb4_left", exp_q.size(), 0);
    chk("cmd4_left", cmd_q.size(), 0);

    // Reset mid-SHIFT of ch1 with ch0 held
    ready = 1'b0;
    cmd_q.push_back(exp_cmd(0));
    en = 1'b1;
    wait_for(0, 1000, "cs_fall5a", n);
    wait_for(1, 200, "cs_rise5", n);
    wait_for(0, 200, "cs_fall5b", n);
    repeat (10) @(posedge clk);
    #1;
    chk("pre_rst_valid", {31'b0, valid}, 1);
    rst_n = 1'b0;
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_cs_n", {31'b0, cs_n}, 1);
    chk("mid_rst_sclk", {31'b0, sclk}, 0);
    chk("mid_rst_valid", {31'b0, valid}, 0);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    rst_n = 1'b1;
    ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_valid", {31'b0, valid}, 0);
    chk("cmd5_left", cmd_q.size(), 0);

    // Period shorter than a scan
    l_en = 1'b1;
    wait_for(3, 5000, "late_run", n);
    l_en = 1'b0;
    chk("late_seen", {31'b0, late_cnt > 0}, 1);

`ifdef ADC_TEST_PATTERN_EN
    tmode = 1'b1;
    mask = 4'b0001;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({2'd0, 12'(i)});
      cmd_q.push_back(exp_cmd(0));
    end
    en = 1'b1;
    wait_for(4, 2000, "ramp_out", n);
    en = 1'b0;
    wait_for(2, 200, "ramp_idle", n);
    repeat (3) @(posedge clk);
    #1;
    chk("cmd7_left", cmd_q.size(), 0);
`endif

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
